// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter slice.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF        = 32;
  localparam int unsigned DATA_W_DEF        = 32;
  localparam int unsigned MAX_CPU_BURST_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    DMA  = 2'd2
  } arbState_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU memory stage, the DMA/debug master and the data memory.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              dma_valid;
  logic              dma_ready;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_last;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_valid, dma_we, dma_addr, dma_wdata, dma_last,
    output dma_ready, dma_rdata, dma_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters and memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_valid, dma_we, dma_addr, dma_wdata, dma_last,
    input  dma_ready, dma_rdata, dma_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_rd_return.sv
// One-stage read return: remembers who issued a load and steers mem_rdata back to that requester.
module dmem_rd_return
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issueRead,
  input  logic              issueOwner,
  input  logic [DATA_W-1:0] memRdata,
  output logic [DATA_W-1:0] cpuRdata,
  output logic              cpuRvalid,
  output logic [DATA_W-1:0] dmaRdata,
  output logic              dmaRvalid
);

  logic              rdPending;
  logic              rdOwner;
  logic [DATA_W-1:0] cpuHold;
  logic [DATA_W-1:0] dmaHold;

  // Reset is folded in so a read caught by reset never returns
  assign cpuRvalid = !reset && rdPending && (rdOwner == OWNER_CPU);
  assign dmaRvalid = !reset && rdPending && (rdOwner == OWNER_DMA);
  assign cpuRdata  = cpuRvalid ? memRdata : cpuHold;
  assign dmaRdata  = dmaRvalid ? memRdata : dmaHold;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPending <= 1'b0;
      rdOwner   <= OWNER_CPU;
      cpuHold   <= '0;
      dmaHold   <= '0;
    end else begin
      rdPending <= issueRead;
      rdOwner   <= issueOwner;
      if (cpuRvalid) cpuHold <= memRdata;
      if (dmaRvalid) dmaHold <= memRdata;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU memory stage and a DMA/debug master.
// Define DMEM_ARB_FAIRNESS_EN to force a waiting DMA in after MAX_CPU_BURST consecutive CPU grants.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
`ifdef DMEM_ARB_FAIRNESS_EN
  ,
  parameter int unsigned MAX_CPU_BURST = MAX_CPU_BURST_DEF
`endif
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  arbState_t         state;
  logic              grantCpu;
  logic              grantDma;
  logic              fairForce;
  logic [ADDR_W-1:0] grantAddr;
  logic [DATA_W-1:0] grantWdata;
  logic [DATA_W-1:0] cpuRdata;
  logic [DATA_W-1:0] dmaRdata;
  logic              cpuRvalid;
  logic              dmaRvalid;

`ifdef DMEM_ARB_FAIRNESS_EN
  localparam int unsigned RUN_W = $clog2(MAX_CPU_BURST + 1);
  logic [RUN_W-1:0] cpuRun;

  assign fairForce = (cpuRun == RUN_W'(MAX_CPU_BURST));

  // Saturating count of CPU grants that made a waiting DMA wait
  always_ff @(posedge clk) begin
    if (reset) begin
      cpuRun <= '0;
    end else if (grantDma) begin
      cpuRun <= '0;
    end else if (grantCpu && bus.dma_valid && !fairForce) begin
      cpuRun <= cpuRun + RUN_W'(1);
    end
  end
`else
  assign fairForce = 1'b0;
`endif

  // Grant decode from current state and requests; nothing is granted while in reset
  always_comb begin
    grantCpu = 1'b0;
    grantDma = 1'b0;
    if (!reset) begin
      case (state)
        DMA: grantDma = bus.dma_valid;
        default: begin
          if (bus.cpu_req && !(bus.dma_valid && fairForce)) grantCpu = 1'b1;
          else if (bus.dma_valid)                            grantDma = 1'b1;
        end
      endcase
    end
  end

  assign grantAddr  = grantDma ? bus.dma_addr  : bus.cpu_addr;
  assign grantWdata = grantDma ? bus.dma_wdata : bus.cpu_wdata;

  assign bus.cpu_stall = !reset && bus.cpu_req && !grantCpu;
  assign bus.dma_ready = grantDma;
  assign bus.mem_en    = grantCpu || grantDma;
  assign bus.mem_we    = (grantCpu && bus.cpu_we) || (grantDma && bus.dma_we);
  assign bus.mem_addr  = grantAddr;
  assign bus.mem_wdata = grantWdata;

  // DMA keeps the memory until its last beat is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        DMA: begin
          if (bus.dma_valid && bus.dma_last) state <= IDLE;
        end
        default: begin
          if (grantCpu)      state <= CPU;
          else if (grantDma) state <= bus.dma_last ? IDLE : DMA;
          else               state <= IDLE;
        end
      endcase
    end
  end

  dmem_rd_return #(.DATA_W(DATA_W)) uRdReturn (
    .clk        (clk),
    .reset      (reset),
    .issueRead  (bus.mem_en && !bus.mem_we),
    .issueOwner (grantDma ? OWNER_DMA : OWNER_CPU),
    .memRdata   (bus.mem_rdata),
    .cpuRdata   (cpuRdata),
    .cpuRvalid  (cpuRvalid),
    .dmaRdata   (dmaRdata),
    .dmaRvalid  (dmaRvalid)
  );

  assign bus.cpu_rdata  = cpuRdata;
  assign bus.cpu_rvalid = cpuRvalid;
  assign bus.dma_rdata  = dmaRdata;
  assign bus.dma_rvalid = dmaRvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboarded bench for dmem_arbiter; a small memory model stands in for data_mem.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned AW = ADDR_W_DEF;
  localparam int unsigned DW = DATA_W_DEF;

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic memLoaded = 1'b0;
  logic [DW-1:0] memArr [256];
  logic [DW-1:0] memRdataR;
  logic [DW-1:0] refMem [256];
  exp_t expQ[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic logic [DW-1:0] initWord(input int i);
    return 32'hA500_0000 + 32'(i) * 32'h0001_0001;
  endfunction

  // Single-port memory with one-cycle read latency
  assign bus.mem_rdata = memRdataR;
  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int i = 0; i < 256; i++) memArr[i] <= initWord(i);
      memLoaded <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) memArr[bus.mem_addr[9:2]] <= bus.mem_wdata;
      else            memRdataR <= memArr[bus.mem_addr[9:2]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpuDrive(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
  endtask

  task automatic dmaDrive(input logic valid, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input logic last);
    bus.dma_valid = valid; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata; bus.dma_last = last;
  endtask

  task automatic test_reset();
    logic [5:0] flags;
    reset = 1'b1;
    cpuDrive(1'b0, 1'b0, '0, '0);
    dmaDrive(1'b0, 1'b0, '0, '0, 1'b0);
    tick(); tick();
    @(negedge clk);
    flags = {bus.cpu_stall, bus.dma_ready, bus.cpu_rvalid, bus.dma_rvalid, bus.mem_en, bus.mem_we};
    total++; if (flags !== 6'b0) begin bad++; $display("FAIL rst_flags: got %b want 000000", flags); end
    total++; if ({bus.cpu_rdata, bus.dma_rdata} !== '0) begin bad++; $display("FAIL rst_rdata: got %h/%h want 0/0", bus.cpu_rdata, bus.dma_rdata); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL rst_state: got %0d want %0d", dut.state, IDLE); end
    total++; if (bus.mem_en !== 1'b0) begin bad++; $display("FAIL rst_idle_mem_en: got %b want 0", bus.mem_en); end
    tick();
  endtask

  task automatic test_cpu_load(output logic [DW-1:0] lastCpu);
    exp_t e;
    cpuDrive(1'b1, 1'b0, 32'h40, '0);
    @(negedge clk);
    total++; if ({bus.mem_en, bus.mem_we, bus.cpu_stall} !== 3'b100) begin bad++; $display("FAIL t1_ctrl: got en/we/stall=%b want 100", {bus.mem_en, bus.mem_we, bus.cpu_stall}); end
    total++; if (bus.mem_addr !== 32'h40) begin bad++; $display("FAIL t1_addr: got %h want 00000040", bus.mem_addr); end
    expQ.push_back('{owner: OWNER_CPU, data: refMem[32'h40 >> 2]});
    tick();
    cpuDrive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    e = expQ.pop_front();
    total++; if ({bus.cpu_rvalid, bus.dma_rvalid} !== 2'b10) begin bad++; $display("FAIL t1_rvalid: got cpu/dma=%b want 10", {bus.cpu_rvalid, bus.dma_rvalid}); end
    total++; if (bus.cpu_rdata !== e.data) begin bad++; $display("FAIL t1_rdata: got %h want %h", bus.cpu_rdata, e.data); end
    lastCpu = e.data;
    tick();
  endtask

  task automatic test_contention(input logic [DW-1:0] lastCpu);
    exp_t e;
    cpuDrive(1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF);
    dmaDrive(1'b1, 1'b0, 32'h80, '0, 1'b1);
    @(negedge clk);
    total++; if ({bus.mem_en, bus.mem_we, bus.dma_ready, bus.cpu_stall} !== 4'b1100) begin bad++; $display("FAIL t2_cpu_wins: got en/we/ready/stall=%b want 1100", {bus.mem_en, bus.mem_we, bus.dma_ready, bus.cpu_stall}); end
    total++; if (bus.mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL t2_wdata: got %h want deadbeef", bus.mem_wdata); end
    refMem[32'h80 >> 2] = 32'hDEAD_BEEF;
    tick();
    cpuDrive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++; if ({bus.dma_ready, bus.mem_en, bus.mem_we} !== 3'b110) begin bad++; $display("FAIL t2_dma_grant: got ready/en/we=%b want 110", {bus.dma_ready, bus.mem_en, bus.mem_we}); end
    expQ.push_back('{owner: OWNER_DMA, data: refMem[32'h80 >> 2]});
    tick();
    dmaDrive(1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    e = expQ.pop_front();
    total++; if ({bus.cpu_rvalid, bus.dma_rvalid} !== 2'b01) begin bad++; $display("FAIL t2_rvalid: got cpu/dma=%b want 01", {bus.cpu_rvalid, bus.dma_rvalid}); end
    total++; if (bus.dma_rdata !== e.data) begin bad++; $display("FAIL t2_dma_rdata: got %h want %h", bus.dma_rdata, e.data); end
    total++; if (bus.cpu_rdata !== lastCpu) begin bad++; $display("FAIL t2_cpu_hold: got %h want %h", bus.cpu_rdata, lastCpu); end
    tick();
  endtask

  task automatic test_dma_burst();
    exp_t e;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int b = 0; b < 4; b++) begin
      a = 32'h100 + 32'(4 * b);
      d = 32'h1000_0000 + 32'(b);
      // The CPU request arrives once the burst has started
      if (b == 0) cpuDrive(1'b0, 1'b0, '0, '0);
      else        cpuDrive(1'b1, 1'b0, 32'h104, '0);
      dmaDrive(1'b1, 1'b1, a, d, b == 3);
      @(negedge clk);
      total++; if ({bus.dma_ready, bus.mem_we, bus.cpu_stall} !== {2'b11, b != 0}) begin bad++; $display("FAIL t3_beat%0d: got ready/we/stall=%b want %b", b, {bus.dma_ready, bus.mem_we, bus.cpu_stall}, {2'b11, b != 0}); end
      total++; if ({bus.mem_addr, bus.mem_wdata} !== {a, d}) begin bad++; $display("FAIL t3_beat%0d_bus: got %h/%h want %h/%h", b, bus.mem_addr, bus.mem_wdata, a, d); end
      refMem[a[9:2]] = d;
      tick();
    end
    dmaDrive(1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    total++; if ({bus.cpu_stall, bus.mem_en} !== 2'b01 || bus.mem_addr !== 32'h104) begin bad++; $display("FAIL t3_cpu_after: got stall/en=%b addr=%h want 01 addr=00000104", {bus.cpu_stall, bus.mem_en}, bus.mem_addr); end
    expQ.push_back('{owner: OWNER_CPU, data: refMem[32'h104 >> 2]});
    tick();
    cpuDrive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    e = expQ.pop_front();
    total++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== e.data) begin bad++; $display("FAIL t3_readback: got v=%b %h want v=1 %h", bus.cpu_rvalid, bus.cpu_rdata, e.data); end
    tick();
  endtask

  task automatic test_dma_bubble();
    exp_t e;
    logic [DW-1:0] firstBeat;
    dmaDrive(1'b1, 1'b0, 32'h100, '0, 1'b0);
    @(negedge clk);
    total++; if ({bus.dma_ready, bus.mem_we} !== 2'b10) begin bad++; $display("FAIL t4_beat0: got ready/we=%b want 10", {bus.dma_ready, bus.mem_we}); end
    expQ.push_back('{owner: OWNER_DMA, data: refMem[32'h100 >> 2]});
    firstBeat = refMem[32'h100 >> 2];
    tick();
    for (int k = 0; k < 2; k++) begin
      dmaDrive(1'b0, 1'b0, '0, '0, 1'b0);
      cpuDrive(1'b1, 1'b0, 32'h108, '0);
      @(negedge clk);
      total++; if ({bus.mem_en, bus.cpu_stall, bus.dma_ready} !== 3'b010) begin bad++; $display("FAIL t4_bubble%0d: got en/stall/ready=%b want 010", k, {bus.mem_en, bus.cpu_stall, bus.dma_ready}); end
      total++; if (dut.state !== DMA) begin bad++; $display("FAIL t4_bubble%0d_state: got %0d want %0d", k, dut.state, DMA); end
      if (k == 0) begin
        e = expQ.pop_front();
        total++; if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== e.data) begin bad++; $display("FAIL t4_beat0_ret: got v=%b %h want v=1 %h", bus.dma_rvalid, bus.dma_rdata, e.data); end
      end else begin
        total++; if (bus.dma_rvalid !== 1'b0 || bus.dma_rdata !== firstBeat) begin bad++; $display("FAIL t4_hold: got v=%b %h want v=0 %h", bus.dma_rvalid, bus.dma_rdata, firstBeat); end
      end
      tick();
    end
    dmaDrive(1'b1, 1'b0, 32'h10C, '0, 1'b1);
    @(negedge clk);
    total++; if ({bus.dma_ready, bus.cpu_stall} !== 2'b11 || bus.mem_addr !== 32'h10C) begin bad++; $display("FAIL t4_last: got ready/stall=%b addr=%h want 11 addr=0000010c", {bus.dma_ready, bus.cpu_stall}, bus.mem_addr); end
    expQ.push_back('{owner: OWNER_DMA, data: refMem[32'h10C >> 2]});
    tick();
    dmaDrive(1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    total++; if (bus.cpu_stall !== 1'b0 || bus.mem_addr !== 32'h108) begin bad++; $display("FAIL t4_cpu_resume: got stall=%b addr=%h want 0 addr=00000108", bus.cpu_stall, bus.mem_addr); end
    e = expQ.pop_front();
    total++; if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== e.data) begin bad++; $display("FAIL t4_last_ret: got v=%b %h want v=1 %h", bus.dma_rvalid, bus.dma_rdata, e.data); end
    expQ.push_back('{owner: OWNER_CPU, data: refMem[32'h108 >> 2]});
    tick();
    cpuDrive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    e = expQ.pop_front();
    total++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== e.data) begin bad++; $display("FAIL t4_cpu_ret: got v=%b %h want v=1 %h", bus.cpu_rvalid, bus.cpu_rdata, e.data); end
    tick();
  endtask

  task automatic test_reset_drop();
    logic [5:0] flags;
    cpuDrive(1'b1, 1'b0, 32'h44, '0);
    @(negedge clk);
    total++; if (bus.mem_en !== 1'b1) begin bad++; $display("FAIL t5_issue: got en=%b want 1", bus.mem_en); end
    tick();
    reset = 1'b1;
    cpuDrive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++; if (bus.cpu_rvalid !== 1'b0) begin bad++; $display("FAIL t5_no_rvalid: got %b want 0", bus.cpu_rvalid); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    flags = {bus.cpu_stall, bus.dma_ready, bus.cpu_rvalid, bus.dma_rvalid, bus.mem_en, bus.mem_we};
    total++; if (flags !== 6'b0 || {bus.cpu_rdata, bus.dma_rdata} !== '0) begin bad++; $display("FAIL t5_outputs: got flags=%b rdata=%h/%h want 0", flags, bus.cpu_rdata, bus.dma_rdata); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL t5_state: got %0d want %0d", dut.state, IDLE); end
    tick();
  endtask

  task automatic test_contention_run();
    exp_t e;
    int period;
    int n;
    logic expDma;
    logic gotV;
    logic [DW-1:0] gotD;
    period = int'(MAX_CPU_BURST_DEF) + 1;
    n = 2 * period;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        cpuDrive(1'b1, 1'b0, 32'h40, '0);
        dmaDrive(1'b1, 1'b0, 32'h80, '0, 1'b1);
      end else begin
        cpuDrive(1'b0, 1'b0, '0, '0);
        dmaDrive(1'b0, 1'b0, '0, '0, 1'b0);
      end
      @(negedge clk);
      if (i > 0) begin
        e = expQ.pop_front();
        gotV = (e.owner == OWNER_CPU) ? bus.cpu_rvalid : bus.dma_rvalid;
        gotD = (e.owner == OWNER_CPU) ? bus.cpu_rdata  : bus.dma_rdata;
        total++; if (gotV !== 1'b1 || gotD !== e.data) begin bad++; $display("FAIL t6_ret%0d: owner=%b got v=%b %h want v=1 %h", i, e.owner, gotV, gotD, e.data); end
      end
      if (i < n) begin
`ifdef DMEM_ARB_FAIRNESS_EN
        expDma = (i % period) == (period - 1);
`else
        expDma = 1'b0;
`endif
        total++; if ({bus.cpu_stall, bus.dma_ready} !== {expDma, expDma}) begin bad++; $display("FAIL t6_grant%0d: got stall/ready=%b want %b", i, {bus.cpu_stall, bus.dma_ready}, {expDma, expDma}); end
        expQ.push_back(expDma ? exp_t'{owner: OWNER_DMA, data: refMem[32'h80 >> 2]}
                              : exp_t'{owner: OWNER_CPU, data: refMem[32'h40 >> 2]});
      end
      tick();
    end
  endtask

  initial begin
    logic [DW-1:0] lastCpu;
    for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
    test_reset();
    test_cpu_load(lastCpu);
    test_contention(lastCpu);
    test_dma_burst();
    test_dma_bubble();
    test_reset_drop();
    test_contention_run();
    total++; if (expQ.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d left want 0", expQ.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
